// File: rtl/seq_det_pkg.sv
// Shared limits, counter op encoding and KMP constant functions for the sequence detector.
// The functions run only at elaboration to build the transition table.
package seq_det_pkg;

    localparam int unsigned LEN_MIN = 2;
    localparam int unsigned LEN_MAX = 16;

    typedef enum logic [1:0] {
        CntHold,
        CntInc,
        CntClr
    } cnt_op_e;

    // Bit i of the received order (i=0 first) lives at pattern[len-1-i].
    function automatic logic pat_bit(input logic [LEN_MAX-1:0] pattern,
                                     input int unsigned len, input int unsigned i);
        logic [3:0] idx;
        idx = 4'(len - 1 - i);
        return pattern[idx];
    endfunction

    // Longest prefix of pattern that is a suffix of (first k pattern bits, then b).
    function automatic int unsigned kmp_next(input int unsigned k, input logic b,
                                             input logic [LEN_MAX-1:0] pattern,
                                             input int unsigned len);
        int unsigned best;
        int unsigned s;
        logic        ok;
        logic        sb;
        best = 0;
        for (int unsigned m = 1; m <= k + 1 && m <= len; m++) begin
            ok = 1'b1;
            for (int unsigned j = 0; j < m; j++) begin
                s  = k + 1 - m + j;
                sb = (s == k) ? b : pat_bit(pattern, len, s);
                if (sb != pat_bit(pattern, len, j)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = m;
            end
        end
        return best;
    endfunction

    // Longest proper prefix of the whole pattern that is also its suffix.
    function automatic int unsigned kmp_fail(input logic [LEN_MAX-1:0] pattern,
                                             input int unsigned len);
        int unsigned best;
        logic        ok;
        best = 0;
        for (int unsigned m = 1; m < len; m++) begin
            ok = 1'b1;
            for (int unsigned j = 0; j < m; j++) begin
                if (pat_bit(pattern, len, j) != pat_bit(pattern, len, len - m + j)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = m;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_hit_counter.sv
// Saturating match counter; clear takes priority over increment.
module seq_hit_counter
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    cnt_op_e          op;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        op = CntHold;
        if (clr_i) begin
            op = CntClr;
        end else if (inc_i) begin
            op = CntInc;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case (op)
            CntClr:  count_d = '0;
            CntInc:  count_d = (count_q == '1) ? count_q : count_q + 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector driven by an elaboration-time KMP transition table.
// Outputs: registered match pulse, progress count, its one-hot copy and a saturating hit count.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned    LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1101,
    parameter bit             OVERLAP = 1'b1,
    parameter int unsigned    CNT_W   = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     en_i,
    input  logic                     w_i,
    input  logic                     clear_count_i,
    output logic                     z_o,
    output logic [$clog2(LEN+1)-1:0] state_o,
    output logic [LEN-1:0]           state_oh_o,
    output logic [CNT_W-1:0]         hit_count_o
);

    localparam int unsigned          SW         = $clog2(LEN + 1);
    localparam logic [LEN_MAX-1:0]   PAT_EXT    = LEN_MAX'(PATTERN);
    localparam int unsigned          RESTART_ST = kmp_fail(PAT_EXT, LEN);

    if (LEN < LEN_MIN || LEN > LEN_MAX) begin : g_len_check
        $error("seq_detector_param: LEN out of range");
    end

    logic [SW-1:0] nxt_tbl [LEN][2];

    for (genvar k = 0; k < LEN; k++) begin : g_row
        for (genvar b = 0; b < 2; b++) begin : g_col
            assign nxt_tbl[k][b] = SW'(kmp_next(k, 1'(b), PAT_EXT, LEN));
        end
    end

    logic [SW-1:0]  state_q;
    logic [SW-1:0]  state_d;
    logic [LEN-1:0] state_oh_q;
    logic [LEN-1:0] state_oh_d;
    logic           z_q;
    logic [SW-1:0]  cand;
    logic           hit;

    always_comb begin
        cand = '0;
        for (int k = 0; k < LEN; k++) begin
            if (state_q == SW'(k)) begin
                cand = nxt_tbl[k][w_i];
            end
        end
        hit        = (cand == SW'(LEN));
        state_d    = hit ? (OVERLAP ? SW'(RESTART_ST) : '0) : cand;
        state_oh_d = LEN'(1) << state_d;
    end

    // state_oh is registered alongside state so both change on the same edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= '0;
            state_oh_q <= LEN'(1);
            z_q        <= 1'b0;
        end else if (en_i) begin
            state_q    <= state_d;
            state_oh_q <= state_oh_d;
            z_q        <= hit;
        end else begin
            z_q        <= 1'b0;
        end
    end

    seq_hit_counter #(
        .CNT_W(CNT_W)
    ) u_hit_counter (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .inc_i  (en_i & hit),
        .clr_i  (clear_count_i),
        .count_o(hit_count_o)
    );

    assign z_o        = z_q;
    assign state_o    = state_q;
    assign state_oh_o = state_oh_q;

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial sequence detector for the board lab top level. It samples a 1-bit serial input `w` on qualified clock edges and recognises a compile-time bit pattern of configurable length, with overlapping or non-overlapping detection. It drives a registered match pulse `z`, a binary progress count, a one-hot state vector for the LEDs, and a saturating hit counter. It generalises the fixed five-state binary and one-hot detectors into a single configurable block.

## Interface
- `LEN`, 4: pattern length in bits. Legal range is 2..16; elaboration fails outside it.
- `PATTERN`, 4'b1101: `LEN`-bit pattern. The MSB is the first bit received.
- `OVERLAP`, 1: 1 allows overlapping matches; 0 restarts from empty after each match.
- `CNT_W`, 8: hit counter width.
- `clk` input 1: the single clock (on the board, `btnC`).
- `reset` input 1: asynchronous, active-high reset (on the board, `btnU`).
- `en` input 1: sample qualifier. `w` is consumed only on a `clk` rise with `en`=1.
- `w` input 1: serial data bit.
- `clear_count` input 1: synchronous clear of `hit_count`.
- `z` output 1: registered match pulse.
- `state` output `$clog2(LEN+1)`: number of pattern bits currently matched (0..`LEN-1`).
- `state_oh` output `LEN`: one-hot copy of `state`. Bit k is high when `state`==k.
- `hit_count` output `CNT_W`: saturating count of matches.

## Operation
- `state` holds k, the length of the longest prefix of `PATTERN` that equals a suffix of the bits sampled so far. It always satisfies k < `LEN`.
- On a sampled bit b at state k (KMP transition):
  - If b equals the next pattern bit (`PATTERN[LEN-1-k]`), the candidate is k+1.
  - Otherwise the next state is the longest prefix of `PATTERN` that is a suffix of (matched k bits followed by b).
- When the candidate reaches `LEN`, a match has occurred:
  - `z` is set for one cycle.
  - `hit_count` increments.
  - `state` becomes the failure value F(`LEN`) if `OVERLAP`=1, or 0 if `OVERLAP`=0.
  - F(k) is the longest proper prefix of `PATTERN[..k]` that is also a suffix of it. For 1101, F(4)=1.
- With `en`=0:
  - `state`, `state_oh` and `hit_count` hold.
  - `z` is 0.
- `hit_count` saturates at 2^`CNT_W`-1 and never wraps.
- `clear_count`=1 sets `hit_count` to 0 on the next edge. If a match occurs on the same edge, the clear wins and the result is 0.
- `clear_count` has no effect on `state` or `z`.
- Reset values:
  - `state`=0
  - `state_oh`=1 (bit 0 set)
  - `z`=0
  - `hit_count`=0
- Reset asserted mid-pattern discards all partial progress immediately. It acts asynchronously and does not wait for a clock edge.

## Timing
- All outputs are registered. There are no combinational paths from the inputs to the outputs.
- `z` rises on the edge that samples the final pattern bit and stays high for exactly one cycle.
- If the next edge is also a completing sample, `z` stays high. This can only happen for overlapping patterns such as 11 with `OVERLAP`=1.
- `state`, `state_oh` and `hit_count` update on the same edge that samples the bit.
- Latency from a sampled bit to the visible update is one cycle.
- There is no handshake beyond `en`. `en` may toggle every cycle.
- Reset deassertion is assumed synchronised externally. The next qualified edge after deassertion samples normally.

## Structure
- Package `seq_det_pkg` contains:
  - the constant function `kmp_next(k, b, pattern, len)`;
  - the constant function `kmp_fail(pattern, len)`;
  - the limits `LEN_MIN`=2 and `LEN_MAX`=16.
- The functions are evaluated at elaboration into a transition table of `LEN` x 2 entries. Nothing is computed at run time.
- Sub-module `seq_hit_counter`: a `CNT_W`-bit saturating counter with `inc`, `clr` (priority over `inc`) and the same `clk`/`reset`.
- `state_oh` is decoded from the registered `state`. It is registered in parallel so it matches `state` exactly every cycle.

## Test plan
- **Overlap match:** default parameters, `en`=1, `w`=1,1,0,1,1,0,1 → `z` pulses after sample 4 and sample 7; `hit_count`=2; `state`=1 after sample 7.
- **Non-overlap match:** `OVERLAP`=0, same 7 bits → `z` pulses after sample 4 only; `hit_count`=1; `state`=1 at end.
- **Enable gating:** send 1,1 with `en`=1, then 5 cycles with `en`=0 and `w` toggling, then 0,1 with `en`=1 → exactly one `z` pulse; `state` holds at 2 throughout the gap.
- **Saturation and clear:** `CNT_W`=2, 5 back-to-back matches → `hit_count`=3. Then assert `clear_count` on the edge of a 6th match → `hit_count`=0 and `z`=1.
- **Reset mid-pattern:** send 1,1,0, then pulse `reset` between edges → `state`=0, `state_oh`=1, `z`=0 immediately. Then send 1 → `state`=1 and no `z`.
- **Alternate pattern:** `LEN`=5, `PATTERN`=5'b10100, `OVERLAP`=1, input 1,0,1,0,1,0,0 → single `z` after sample 7; `state`=0 at end (F=0).
